// File: rtl/wb_stream_reader_cfg_mc.sv
// Multi-channel Wishbone config/status block for stream reader DMA engines.
// Ports: classic Wishbone slave (wb_*), irq_o/ch_irq interrupts, per-channel
// busy/tx_cnt inputs and enable/start_adr/buf_size/burst_size outputs.
module wb_stream_reader_cfg_mc #(
    parameter int WB_AW    = 32,
    parameter int WB_DW    = 32,
    parameter int N_CH     = 2,
    parameter int TX_SHIFT = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic [6:0]            wb_adr_i,
    input  logic [WB_DW-1:0]      wb_dat_i,
    input  logic [WB_DW/8-1:0]    wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic [WB_DW-1:0]      wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  irq_o,
    output logic [N_CH-1:0]       ch_irq,
    input  logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       enable,
    input  logic [N_CH*WB_DW-1:0] tx_cnt,
    output logic [N_CH*WB_AW-1:0] start_adr,
    output logic [N_CH*WB_AW-1:0] buf_size,
    output logic [N_CH*WB_AW-1:0] burst_size
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    logic [1:0]       ch;
    logic [2:0]       rsel;
    logic             acc;
    logic             ch_ok;
    logic             wr;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic [WB_DW-1:0] rdata;
    logic [WB_DW-1:0] tx_sel;

    logic [N_CH-1:0]       mask_v;
    logic [N_CH*6-1:0]     stat_v;
    logic [N_CH*WB_DW-1:0] cnt_v;

    logic unused_ok;
    assign unused_ok = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign ch   = wb_adr_i[6:5];
    assign rsel = wb_adr_i[4:2];
    // Holding off while ack/err is up forces at least two cycles per access.
    assign acc   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign ch_ok = {1'b0, ch} < 3'(N_CH);
    assign wr    = acc & ch_ok & wb_we_i;

    always_comb begin
        ack_d = acc & ch_ok;
        err_d = acc & ~ch_ok;
        dat_d = dat_q;
        if (acc) dat_d = ch_ok ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_e           st_q, st_d;
        logic             en_q, en_d;
        logic             irq_q, irq_d;
        logic             mask_q, mask_d;
        logic             cont_q, cont_d;
        logic             bsy_q;
        logic [WB_DW-1:0] cnt_q, cnt_d;
        logic [WB_AW-1:0] adr_q, adr_d;
        logic [WB_AW-1:0] bsz_q, bsz_d;
        logic [WB_AW-1:0] bst_q, bst_d;
        logic             hit, ctrl_wr, start, clr, abort;
        logic             rise, fall, done, cnt_clr;

        assign hit     = wr && (ch == 2'(c));
        assign ctrl_wr = hit && (rsel == 3'd0);
        assign start   = ctrl_wr & wb_dat_i[0];
        assign clr     = ctrl_wr & wb_dat_i[1];
        assign abort   = ctrl_wr & wb_dat_i[2];
        assign cnt_clr = hit && (rsel == 3'd6);
        assign rise    = ~bsy_q & busy[c];
        assign fall    = bsy_q & ~busy[c];
        // Abort suppresses a completion landing in the same cycle.
        assign done    = (st_q == S_RUN) & fall & ~abort;

        always_comb begin
            st_d   = st_q;
            en_d   = en_q;
            cont_d = ctrl_wr ? wb_dat_i[3] : cont_q;
            mask_d = (hit && rsel == 3'd5) ? wb_dat_i[0] : mask_q;
            adr_d  = (hit && rsel == 3'd1) ? wb_dat_i[WB_AW-1:0] : adr_q;
            bsz_d  = (hit && rsel == 3'd2) ? wb_dat_i[WB_AW-1:0] : bsz_q;
            bst_d  = (hit && rsel == 3'd3) ? wb_dat_i[WB_AW-1:0] : bst_q;
            case (st_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        st_d = S_ARMED;
                        en_d = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (rise) st_d = S_RUN;
                end
                S_RUN: begin
                    if (fall) begin
                        st_d = cont_q ? S_ARMED : S_DONE;
                        en_d = cont_q;
                    end
                end
                default: ;
            endcase
            if (abort) begin
                st_d = S_IDLE;
                en_d = 1'b0;
            end
            // Completion wins over a simultaneous clear.
            irq_d = done | (irq_q & ~clr);
            // Clear then increment, so a colliding clear+done leaves 1.
            cnt_d = cnt_clr ? '0 : cnt_q;
            if (done) cnt_d = cnt_d + WB_DW'(1);
        end

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                st_q   <= S_IDLE;
                en_q   <= 1'b0;
                irq_q  <= 1'b0;
                mask_q <= 1'b1;
                cont_q <= 1'b0;
                bsy_q  <= 1'b0;
                cnt_q  <= '0;
                adr_q  <= '0;
                bsz_q  <= WB_AW'(100);
                bst_q  <= WB_AW'(2);
            end else begin
                st_q   <= st_d;
                en_q   <= en_d;
                irq_q  <= irq_d;
                mask_q <= mask_d;
                cont_q <= cont_d;
                bsy_q  <= busy[c];
                cnt_q  <= cnt_d;
                adr_q  <= adr_d;
                bsz_q  <= bsz_d;
                bst_q  <= bst_d;
            end
        end

        assign enable[c] = en_q;
        assign ch_irq[c] = irq_q;
        assign mask_v[c] = mask_q;
        assign start_adr[c*WB_AW +: WB_AW]  = adr_q;
        assign buf_size[c*WB_AW +: WB_AW]   = bsz_q;
        assign burst_size[c*WB_AW +: WB_AW] = bst_q;
        assign cnt_v[c*WB_DW +: WB_DW]      = cnt_q;
        assign stat_v[c*6 +: 6] = {st_q, cont_q, mask_q, irq_q, busy[c]};
    end

    always_comb begin
        rdata  = '0;
        tx_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch == 2'(c)) begin
                tx_sel = tx_cnt[c*WB_DW +: WB_DW];
                case (rsel)
                    3'd0: rdata[5:0] = stat_v[c*6 +: 6];
                    3'd1: rdata = WB_DW'(start_adr[c*WB_AW +: WB_AW]);
                    3'd2: rdata = WB_DW'(buf_size[c*WB_AW +: WB_AW]);
                    3'd3: rdata = WB_DW'(burst_size[c*WB_AW +: WB_AW]);
                    3'd4: rdata = tx_sel << TX_SHIFT;
                    3'd5: rdata[0] = mask_v[c];
                    3'd6: rdata = cnt_v[c*WB_DW +: WB_DW];
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign irq_o = |(ch_irq & mask_v);

endmodule

// File: tb/tb_wb_stream_reader_cfg_mc.sv
// Testbench for wb_stream_reader_cfg_mc: table-driven register vectors
// plus directed sequences for the channel state machines.
module tb_wb_stream_reader_cfg_mc;

    logic        clk;
    logic        rst_n;
    logic [6:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] rdat;
    logic        ack, err;
    logic        irq_o;
    logic [1:0]  ch_irq;
    logic [1:0]  busy;
    logic [1:0]  enable;
    logic [63:0] tx_cnt;
    logic [63:0] start_adr, buf_size, burst_size;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    wb_stream_reader_cfg_mc dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (wdat),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_cti_i   (cti),
        .wb_bte_i   (bte),
        .wb_dat_o   (rdat),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .irq_o      (irq_o),
        .ch_irq     (ch_irq),
        .busy       (busy),
        .enable     (enable),
        .tx_cnt     (tx_cnt),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [6:0]  adr;
        logic [31:0] wdat;
        logic        chk;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic add(input string n, input logic w, input logic [6:0] a,
                       input logic [31:0] d, input logic c,
                       input logic [31:0] e, input logic er);
        vec_t v;
        v.name = n; v.we = w; v.adr = a; v.wdat = d;
        v.chk = c; v.exp = e; v.err = er;
        vt.push_back(v);
    endtask

    task automatic wb_begin(input logic w, input logic [6:0] a,
                            input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    endtask

    task automatic wb_end(output logic [31:0] rd, output logic ak,
                          output logic er);
        logic got;
        got = 1'b0;
        rd = '0; ak = 1'b0; er = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ack || err) begin
                got = 1'b1;
                break;
            end
        end
        rd = rdat; ak = ack; er = err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            tot_cnt++;
            $display("FAIL bus_timeout: got no ack/err want ack or err");
        end
    endtask

    task automatic xfer(input logic w, input logic [6:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic ak, output logic er);
        @(negedge clk);
        wb_begin(w, a, d);
        wb_end(rd, ak, er);
    endtask

    task automatic wr32(input logic [6:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic ak, er;
        xfer(1'b1, a, d, rd, ak, er);
    endtask

    task automatic rd_chk(input string n, input logic [6:0] a,
                          input logic [31:0] e);
        logic [31:0] rd;
        logic ak, er;
        xfer(1'b0, a, 32'h0, rd, ak, er);
        check(n, {ak, rd}, {1'b1, e});
    endtask

    task automatic pulse(input int c, input int n);
        @(negedge clk);
        busy[c] = 1'b1;
        repeat (n) @(negedge clk);
        busy[c] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    logic a_f, e_f;

    initial begin
        rst_n = 1'b1;
        adr = '0; wdat = '0; sel = 4'hF; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
        busy = '0;
        tx_cnt = {32'h0000_0040, 32'h4000_0001};

        #2 rst_n = 1'b0;
        #1;
        check("rst_ack_err", {ack, err}, 0);
        check("rst_dat", rdat, 0);
        check("rst_enable", enable, 0);
        check("rst_irq", {irq_o, ch_irq}, 0);
        check("rst_start_adr", start_adr, 0);
        check("rst_buf_size", buf_size, {32'd100, 32'd100});
        check("rst_burst_size", burst_size, {32'd2, 32'd2});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        add("rd_ch1_bufsz",  0, 7'h28, 0, 1, 100, 0);
        add("rd_ch1_burst",  0, 7'h2C, 0, 1, 2, 0);
        add("rd_ch0_status", 0, 7'h00, 0, 1, 32'h04, 0);
        add("rd_ch0_mask",   0, 7'h14, 0, 1, 1, 0);
        add("rd_ch0_done",   0, 7'h18, 0, 1, 0, 0);
        add("rd_ch1_adr",    0, 7'h24, 0, 1, 0, 0);
        add("wr_ch0_adr",    1, 7'h04, 32'h1000, 0, 0, 0);
        add("rd_ch0_adr",    0, 7'h04, 0, 1, 32'h1000, 0);
        add("wr_ch1_burst",  1, 7'h2C, 32'h10, 0, 0, 0);
        add("rd_ch1_burst2", 0, 7'h2C, 0, 1, 32'h10, 0);
        add("wr_ch0_rsv",    1, 7'h1C, 32'hFFFF_FFFF, 0, 0, 0);
        add("rd_ch0_rsv",    0, 7'h1C, 0, 1, 0, 0);
        add("rd_ch0_tx",     0, 7'h10, 0, 1, 32'h4, 0);
        add("rd_ch1_tx",     0, 7'h30, 0, 1, 32'h100, 0);
        add("wr_ch2_err",    1, 7'h48, 32'hDEAD, 1, 0, 1);
        add("rd_ch2_err",    0, 7'h48, 0, 1, 0, 1);
        add("rd_ch3_err",    0, 7'h60, 0, 1, 0, 1);
        add("rd_ch0_bufsz",  0, 7'h08, 0, 1, 100, 0);
        add("rd_ch1_bufsz2", 0, 7'h28, 0, 1, 100, 0);

        foreach (vt[i]) begin
            xfer(vt[i].we, vt[i].adr, vt[i].wdat, r, a_f, e_f);
            check({vt[i].name, "_resp"}, {a_f, e_f}, {~vt[i].err, vt[i].err});
            if (vt[i].chk) check({vt[i].name, "_dat"}, r, vt[i].exp);
            @(posedge clk);
            #1;
            check({vt[i].name, "_1cyc"}, {ack, err}, 0);
        end

        check("out_start_adr0", start_adr[31:0], 32'h1000);
        check("out_burst1", burst_size[63:32], 32'h10);
        check("out_bufsz", buf_size, {32'd100, 32'd100});

        // One-shot on channel 0
        wr32(7'h00, 32'h1);
        check("os_en_on", enable[0], 1);
        pulse(0, 10);
        check("os_en_off", enable[0], 0);
        check("os_ch_irq", ch_irq[0], 1);
        check("os_irq_o", irq_o, 1);
        rd_chk("os_done_cnt", 7'h18, 1);
        rd_chk("os_status", 7'h00, 32'h36);
        wr32(7'h00, 32'h2);
        check("os_clr_irq", {irq_o, ch_irq[0]}, 0);

        // Continuous on channel 1
        wr32(7'h20, 32'h9);
        check("ct_en_on", enable[1], 1);
        for (int p = 0; p < 3; p++) begin
            pulse(1, 3);
            check($sformatf("ct_en_held%0d", p), enable[1], 1);
        end
        rd_chk("ct_done_cnt", 7'h38, 3);
        rd_chk("ct_status", 7'h20, 32'h1E);
        wr32(7'h20, 32'h4);
        check("ct_abort_en", enable[1], 0);
        rd_chk("ct_status_idle", 7'h20, 32'h06);
        wr32(7'h20, 32'h2);
        check("ct_clr_irq", ch_irq[1], 0);

        // Masked completion on channel 0
        wr32(7'h14, 32'h0);
        wr32(7'h00, 32'h1);
        pulse(0, 3);
        check("mk_ch_irq", ch_irq[0], 1);
        check("mk_irq_o", irq_o, 0);

        // Clear-irq write landing on the busy fall edge
        wr32(7'h00, 32'h1);
        @(negedge clk);
        busy[0] = 1'b1;
        repeat (3) @(negedge clk);
        wb_begin(1'b1, 7'h00, 32'h2);
        busy[0] = 1'b0;
        wb_end(r, a_f, e_f);
        check("col_ack", a_f, 1);
        check("col_irq_kept", ch_irq[0], 1);
        check("col_en_off", enable[0], 0);
        rd_chk("col_done3", 7'h18, 3);

        // DONE_CNT clear landing on a completion
        wr32(7'h00, 32'h1);
        @(negedge clk);
        busy[0] = 1'b1;
        repeat (3) @(negedge clk);
        wb_begin(1'b1, 7'h18, 32'h0);
        busy[0] = 1'b0;
        wb_end(r, a_f, e_f);
        rd_chk("col_cnt_one", 7'h18, 1);

        // Abort together with start: abort wins
        wr32(7'h00, 32'h5);
        check("abst_en", enable[0], 0);
        rd_chk("abst_status", 7'h00, 32'h02);

        // Abort during RUN: no irq, no count
        wr32(7'h00, 32'h2);
        wr32(7'h00, 32'h1);
        @(negedge clk);
        busy[0] = 1'b1;
        repeat (2) @(negedge clk);
        wr32(7'h00, 32'h4);
        check("abrun_en", enable[0], 0);
        busy[0] = 1'b0;
        @(posedge clk);
        #1;
        check("abrun_irq", ch_irq[0], 0);
        rd_chk("abrun_cnt", 7'h18, 1);

        // Asynchronous reset mid-transfer
        wr32(7'h00, 32'h1);
        check("rs_en_on", enable[0], 1);
        busy[0] = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rs_en_off", enable, 0);
        check("rs_adr", start_adr, 0);
        busy[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rs_mask", 7'h14, 1);
        rd_chk("rs_cnt", 7'h18, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
